// File: rtl/gin_leak_pkg.sv
// Shared widths, FSM states and saturation limits
// for the conductance-leak sequential divider.
package gin_leak_pkg;

  localparam int INTEGER_WIDTH   = 32;
  localparam int DATA_WIDTH_FRAC = 32;
  localparam int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC;

  typedef enum logic [2:0] {
    IDLE,
    SIGN,
    DIV,
    FIX,
    DONE
  } state_t;

  localparam logic [DATA_WIDTH-1:0] QMAX =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] QMIN =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/gin_leak_seq_divider_step.sv
// One restoring-division step: shift in the next
// dividend bit, subtract the divisor if it fits.
module div_restoring_step #(
  parameter int W = 33
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] dvs,
  input  logic         dbit,
  output logic [W-1:0] next_rem,
  output logic         qbit
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;

  assign shifted = {rem, dbit};
  // the difference is below dvs whenever it is used
  assign diff     = shifted[W-1:0] - dvs;
  assign qbit     = shifted >= {1'b0, dvs};
  assign next_rem = qbit ? diff : shifted[W-1:0];

endmodule

// File: rtl/gin_leak_seq_divider.sv
// Exact signed Q-format / integer divider, one bit per
// cycle, fixed latency, single request in flight.
module gin_leak_seq_divider #(
  parameter int INTEGER_WIDTH   = 32,
  parameter int DATA_WIDTH_FRAC = 32,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int TAG_WIDTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [DATA_WIDTH-1:0]    dividend,
  input  logic [INTEGER_WIDTH-1:0] divisor,
  input  logic [TAG_WIDTH-1:0]     req_tag,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    quotient,
  output logic [TAG_WIDTH-1:0]     resp_tag,
  output logic                     div_by_zero,
  output logic                     overflow
);

  import gin_leak_pkg::*;

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t state;
  state_t state_nx;

  logic                     alive;
  logic                     accept;
  logic [DATA_WIDTH-1:0]    dend;
  logic [INTEGER_WIDTH-1:0] dvs;
  logic [TAG_WIDTH-1:0]     tag;
  logic [DATA_WIDTH:0]      dmag;
  logic [INTEGER_WIDTH:0]   vmag;
  logic [INTEGER_WIDTH:0]   rem;
  logic [INTEGER_WIDTH:0]   rem_nx;
  logic                     qbit;
  logic [DATA_WIDTH-1:0]    quo;
  logic [CW-1:0]            cnt;
  logic                     neg;
  logic                     dneg;
  logic                     zflag;
  logic                     oflag;
  logic [DATA_WIDTH-1:0]    result;

  // ready stays low until the first edge after reset release
  assign req_ready  = alive && (state == IDLE);
  assign resp_valid = (state == DONE);
  assign accept     = req_valid && req_ready;

  div_restoring_step #(
    .W (INTEGER_WIDTH + 1)
  ) u_step (
    .rem      (rem),
    .dvs      (vmag),
    .dbit     (dmag[cnt]),
    .next_rem (rem_nx),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nx;
      alive <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = SIGN;
      SIGN: state_nx = DIV;
      DIV:  if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // special cases override the divide result; 0 never turns into -0
  always_comb begin
    result = neg ? -quo : quo;
    unique case (1'b1)
      zflag:   result = dneg ? SAT_MIN : SAT_MAX;
      oflag:   result = SAT_MAX;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dend        <= '0;
      dvs         <= '0;
      tag         <= '0;
      dmag        <= '0;
      vmag        <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      dneg        <= 1'b0;
      zflag       <= 1'b0;
      oflag       <= 1'b0;
      quotient    <= '0;
      resp_tag    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            dend <= dividend;
            dvs  <= divisor;
            tag  <= req_tag;
          end
        end
        SIGN: begin
          dneg  <= dend[DATA_WIDTH-1];
          neg   <= dend[DATA_WIDTH-1] ^ dvs[INTEGER_WIDTH-1];
          dmag  <= dend[DATA_WIDTH-1]
                   ? -{dend[DATA_WIDTH-1], dend}
                   : {dend[DATA_WIDTH-1], dend};
          vmag  <= dvs[INTEGER_WIDTH-1]
                   ? -{dvs[INTEGER_WIDTH-1], dvs}
                   : {dvs[INTEGER_WIDTH-1], dvs};
          zflag <= (dvs == '0);
          oflag <= (dend == SAT_MIN) && (dvs == '1);
          rem   <= '0;
          quo   <= '0;
          cnt   <= CW'(DATA_WIDTH - 1);
        end
        DIV: begin
          rem <= rem_nx;
          quo <= {quo[DATA_WIDTH-2:0], qbit};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          quotient    <= result;
          resp_tag    <= tag;
          div_by_zero <= zflag;
          overflow    <= oflag;
        end
        DONE: begin
          if (resp_ready) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gin_leak_seq_divider.md
Name: gin_leak_seq_divider

Overview:
- Multi-cycle exact signed fixed-point divider. It is the responder side of the conductance-leak datapath's divide request.
- A leak unit issues the request: dividend = -gin*DeltaT in Q(INTEGER_WIDTH).(DATA_WIDTH_FRAC) format, divisor = integer tau.
- The block returns the truncated quotient in the same Q format over a valid/ready handshake.
- It replaces the single-cycle approximate divider where accuracy matters more than throughput, one request in flight at a time.

Parameters:
- INTEGER_WIDTH, 32, integer bits of dividend/quotient; full width of divisor.
- DATA_WIDTH_FRAC, 32, fractional bits of dividend/quotient.
- DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, total dividend/quotient width.
- TAG_WIDTH, 8, opaque request tag (neuron index) returned with the result.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request.
- Dividend  in  DATA_WIDTH  signed Q-format dividend.
- Divisor  in  INTEGER_WIDTH  signed integer divisor.
- ReqTag  in  TAG_WIDTH  tag captured with the request.
- RespValid  out  1  result present.
- RespReady  in  1  consumer accepts result.
- Quotient  out  DATA_WIDTH  signed Q-format quotient.
- RespTag  out  TAG_WIDTH  tag of the returned result.
- DivByZero  out  1  result produced with Divisor==0.
- Overflow  out  1  result saturated (most-negative / -1).

Behaviour:
- Reset (async, Reset=0): state IDLE. ReqReady=0 while Reset low, 1 from first edge after release. RespValid=0, Quotient=0, RespTag=0, DivByZero=0, Overflow=0. Internal registers cleared.
- Arithmetic: divisor is integer, so Q-format quotient = raw Dividend / Divisor as integers, no pre-shift. Truncate toward zero. Remainder discarded.
- States:
  - IDLE: ReqReady=1. On ReqValid&ReqReady, capture operands and tag -> SIGN.
  - SIGN (1 cycle): record result sign = sign(Dividend) XOR sign(Divisor). Take magnitudes (DATA_WIDTH+1 bits, so the most-negative value is safe). Flag zero/overflow. Load counter = DATA_WIDTH-1 -> DIV.
  - DIV (DATA_WIDTH cycles): restoring division, one quotient bit per cycle, MSB first. Counter decrements; at 0 -> FIX.
  - FIX (1 cycle): apply sign, apply saturation, load output registers -> DONE.
  - DONE: RespValid=1, outputs stable until RespReady. On RespValid&RespReady -> IDLE.
- ReqReady=0 in every state except IDLE. No request accepted in the same cycle a response is consumed.
- Latency: RespValid rises DATA_WIDTH+2 rising edges after the accepting edge (66 at defaults). Constant for all operands, including the special cases below.
- Divisor==0: DIV still runs, but its result is ignored. Quotient = +max (0x7FFF..F) if Dividend>=0, else most-negative (0x8000..0). DivByZero=1, Overflow=0.
- Dividend==most-negative and Divisor==-1: Quotient = +max, Overflow=1.
- Dividend==0: Quotient=0, no flags, including negative divisors (no negative zero).
- Flags are valid only with RespValid and are cleared on handshake completion.
- Backpressure: DONE holds all outputs indefinitely. Changes on Dividend/Divisor/ReqValid while busy have no effect.
- Reset asserted mid-operation: immediate return to IDLE/reset values, in-flight request dropped, no response emitted.

Decomposition:
- Shared package gin_leak_pkg:
  - default width constants (INTEGER_WIDTH, DATA_WIDTH_FRAC, DATA_WIDTH);
  - state enum {IDLE, SIGN, DIV, FIX, DONE};
  - saturation constants QMAX/QMIN as functions of DATA_WIDTH.
- One sub-module is natural: div_restoring_step. It is combinational: partial remainder, divisor, next dividend bit in -> new remainder and quotient bit out. The FSM, sign and saturation logic stay in the top.

Test Plan:
- Basic and handshake: Dividend=0x0000_0006_0000_0000 (6.0), Divisor=4, tag 0x12 -> Quotient=0x0000_0001_8000_0000 (1.5), RespTag=0x12, no flags. RespValid exactly 66 edges after accept; ReqReady=0 throughout.
- Sign handling:
  - -6.0/4 -> 0xFFFF_FFFE_8000_0000 (-1.5);
  - 6.0/-4 -> same;
  - -6.0/-4 -> 1.5;
  - 0x0000_0000_0000_0007 / 2 -> 0x3 (truncation);
  - -7 raw / 2 -> -3 raw (0xFFFF_FFFF_FFFF_FFFD).
- Special cases:
  - Divisor=0, Dividend=5.0 -> 0x7FFF_FFFF_FFFF_FFFF, DivByZero=1;
  - Divisor=0, Dividend=-1 raw -> 0x8000_0000_0000_0000, DivByZero=1;
  - 0x8000_0000_0000_0000 / -1 -> 0x7FFF_FFFF_FFFF_FFFF, Overflow=1;
  - each with latency still 66.
- Backpressure: RespReady held 0 for 20 cycles after RespValid. Outputs stable, a ReqValid pulse is ignored. RespReady=1 -> IDLE next edge, new request accepted after.
- Reset mid-op: Reset=0 at DIV cycle 30. All outputs go to reset values asynchronously, no RespValid follows. A fresh request after release completes correctly.
- Random: 10k random operand/tag pairs with random RespReady stalls. Compared against a truncating reference model; one response per request, tags in order.
